// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if
//   Request/response bundle between the ALU issue logic (master) and the
//   sequential Booth multiplier (slave).
//   start        : request, sampled only while the multiplier is idle
//   flush        : synchronous pipeline cancel
//   multiplier   : signed operand, scanned LSB-first
//   multiplicand : signed operand, added/subtracted each step
//   busy         : high while an operation is running
//   done         : one-cycle pulse when product is valid
//   product      : signed 2*WIDTH result, held until the next completion
interface booth_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 flush;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, flush, multiplier, multiplicand,
    input  busy, done, product
  );

  modport slave (
    input  start, flush, multiplier, multiplicand,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
//   Sequential radix-2 Booth multiply controller. One add/subtract-and-shift
//   step per clock; full signed 2*WIDTH product returned with a done pulse.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : booth_seq_ctrl_if.slave (start, flush, operands, busy, done,
//             product)
//   Optional feature: define BOOTH_EARLY_TERM_EN to finish as soon as the
//   remaining multiplier bits can no longer cause an add/subtract
//   (variable latency 1..WIDTH, identical results).
module booth_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_seq_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH:0]     a_step;
  logic signed [SW-1:0] step_cat;
  logic signed [SW-1:0] step_res;
  logic               last_step;

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH:0]     win_mask;
  logic               early_hit;
  logic [CW-1:0]      shamt;
  logic signed [PW:0] aq_cat;
  logic signed [PW:0] aq_shr;
`endif

  // One Booth step: add/subtract on {Q[0],q_1}, then arithmetic shift of
  // {A,Q,q_1}. A is one bit wider than the operands so -2^(WIDTH-1)
  // multiplicands cannot overflow.
  always_comb begin
    case ({q_q[0], q1_q})
      2'b10:   a_step = a_q - m_q;
      2'b01:   a_step = a_q + m_q;
      default: a_step = a_q;
    endcase
    step_cat  = {a_step, q_q, q1_q};
    step_res  = step_cat >>> 1;
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef BOOTH_EARLY_TERM_EN
  // Unconsumed multiplier bits sit in Q[WIDTH-1-cnt:0]; together with q_1
  // they form bits [WIDTH-cnt:0] of {Q,q_1}. If they all match, every
  // remaining step is a pure shift, so collapse them into one shift.
  always_comb begin
    win_mask  = {(WIDTH+1){1'b1}} >> cnt_q;
    early_hit = ((({q_q, q1_q}) ^ {(WIDTH+1){q1_q}}) & win_mask) == '0;
    shamt     = CW'(WIDTH) - cnt_q;
    aq_cat    = {a_q, q_q};
    aq_shr    = aq_cat >>> shamt;
  end
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          q1_d    = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          a_d   = step_res[SW-1:WIDTH+1];
          q_d   = step_res[WIDTH:1];
          q1_d  = step_res[0];
          cnt_d = cnt_q + 1'b1;
`ifdef BOOTH_EARLY_TERM_EN
          if (early_hit) begin
            product_d = PW'(aq_shr);
            done_d    = 1'b1;
            state_d   = IDLE;
          end else if (last_step) begin
            product_d = step_res[PW:1];
            done_d    = 1'b1;
            state_d   = IDLE;
          end
`else
          if (last_step) begin
            product_d = step_res[PW:1];
            done_d    = 1'b1;
            state_d   = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
